// File: rtl/arb_mux.sv
// Registered N-way arbitrating multiplexer: fixed-priority or round-robin grant
// feeding a one-entry output register with valid/ready on every side.
module arb_mux #(
  parameter int WIDTH = 64,
  parameter int CNT   = 2,
  parameter int RR    = 0,
  localparam int SELW = (CNT > 1) ? $clog2(CNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT-1:0]   in_valid,
  input  logic [WIDTH-1:0] in_data [CNT-1:0],
  output logic [CNT-1:0]   in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             grant_vld_s;
  logic [SELW-1:0]  grant_idx_s;
  logic             space_s;
  logic             accept_s;

  // Grant search: scan from ptr (round-robin) or from 0 (fixed), wrapping at CNT.
  always_comb begin : p_grant
    logic [SELW:0]   pos_s;
    logic [SELW-1:0] idx_s;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    pos_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < CNT; k++) begin
      if (RR != 0) begin
        pos_s = {1'b0, ptr_q} + (SELW+1)'(k);
      end else begin
        pos_s = (SELW+1)'(k);
      end
      if (pos_s >= (SELW+1)'(CNT)) begin
        pos_s = pos_s - (SELW+1)'(CNT);
      end else begin
        pos_s = pos_s;
      end
      idx_s = pos_s[SELW-1:0];
      if (!grant_vld_s && in_valid[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Handshake: only the granted channel sees ready, and only when the register can take it.
  always_comb begin : p_ready
    space_s  = !out_valid_q || out_ready;
    accept_s = grant_vld_s && space_s;
    in_ready = '0;
    for (int i = 0; i < CNT; i++) begin
      if (accept_s && (grant_idx_s == SELW'(i))) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Output register and pointer next-state; a drain with a refill stays FULL.
  always_comb begin : p_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx_s];
      out_sel_d   = grant_idx_s;
      if (RR == 0) begin
        ptr_d = ptr_q;
      end else if (grant_idx_s == SELW'(CNT-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: four configurations checked against a per-cycle behavioural
// model, plus directed scenarios with hand-computed literal expectations.
module tb_arb_mux;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [3:0] iv   [4];
  logic       ordy [4];
  logic [7:0] idat [4][4];

  logic [7:0] d0 [3:0];
  logic [7:0] d1 [2:0];
  logic [7:0] d2 [1:0];
  logic [7:0] d3 [0:0];

  logic [3:0] ir0;
  logic [2:0] ir1;
  logic [1:0] ir2;
  logic [0:0] ir3;
  logic       ov0, ov1, ov2, ov3;
  logic [7:0] od0, od1, od2, od3;
  logic [1:0] os0, os1;
  logic [0:0] os2, os3;

  logic [3:0] dir [4];
  logic       dov [4];
  logic [7:0] dod [4];
  logic [1:0] dos [4];

  logic       mvalid [4];
  logic [7:0] mdata  [4];
  logic [1:0] msel   [4];
  int         mptr   [4];

  always_comb begin
    for (int j = 0; j < 4; j++) d0[j] = idat[0][j];
    for (int j = 0; j < 3; j++) d1[j] = idat[1][j];
    for (int j = 0; j < 2; j++) d2[j] = idat[2][j];
    d3[0] = idat[3][0];
  end

  arb_mux #(.WIDTH(8), .CNT(4), .RR(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(d0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));
  arb_mux #(.WIDTH(8), .CNT(3), .RR(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1][2:0]), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));
  arb_mux #(.WIDTH(8), .CNT(2), .RR(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2][1:0]), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));
  arb_mux #(.WIDTH(8), .CNT(1), .RR(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3][0:0]), .in_data(d3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy[3]));

  assign dir[0] = ir0;
  assign dir[1] = {1'b0, ir1};
  assign dir[2] = {2'b00, ir2};
  assign dir[3] = {3'b000, ir3};
  assign dov[0] = ov0;
  assign dov[1] = ov1;
  assign dov[2] = ov2;
  assign dov[3] = ov3;
  assign dod[0] = od0;
  assign dod[1] = od1;
  assign dod[2] = od2;
  assign dod[3] = od3;
  assign dos[0] = os0;
  assign dos[1] = os1;
  assign dos[2] = {1'b0, os2};
  assign dos[3] = {1'b0, os3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cnt_of(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit rr_of(input int k);
    return (k == 1) || (k == 2);
  endfunction

  // Model grant: first valid channel in scan order starting at ptr (or 0), -1 if none.
  function automatic int mgrant(input int k, input logic [3:0] v, input int p);
    int c;
    int i;
    c = cnt_of(k);
    for (int j = 0; j < c; j++) begin
      i = rr_of(k) ? (p + j) % c : j;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state update on each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mvalid[k] <= 1'b0;
        mdata[k]  <= 8'h00;
        msel[k]   <= 2'd0;
        mptr[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int g;
        g = mgrant(k, iv[k], mptr[k]);
        if (g >= 0 && (!mvalid[k] || ordy[k])) begin
          mvalid[k] <= 1'b1;
          mdata[k]  <= idat[k][g];
          msel[k]   <= 2'(g);
          mptr[k]   <= (g + 1) % cnt_of(k);
        end else if (ordy[k]) begin
          mvalid[k] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        int g;
        logic [3:0] er;
        g  = mgrant(k, iv[k], mptr[k]);
        er = (g >= 0 && (!mvalid[k] || ordy[k])) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("model_in_ready[%0d]", k), 32'(dir[k]), 32'(er));
        chk($sformatf("model_out_valid[%0d]", k), 32'(dov[k]), 32'(mvalid[k]));
        chk($sformatf("model_out_data[%0d]", k), 32'(dod[k]), 32'(mdata[k]));
        chk($sformatf("model_out_sel[%0d]", k), 32'(dos[k]), 32'(msel[k]));
      end
    end
  end

  logic [7:0] rr_exp [5];

  initial begin
    checks = 0;
    errors = 0;
    rr_exp = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11};
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv[k]   = 4'b0000;
      ordy[k] = 1'b0;
      for (int j = 0; j < 4; j++) idat[k][j] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Mid-operation reset; u1 also moves its pointer to 2 beforehand.
    @(posedge clk); #1;
    iv[0] = 4'b0100; idat[0][2] = 8'hAA; ordy[0] = 1'b0;
    iv[1] = 4'b0010; idat[1][1] = 8'h77; ordy[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(ov0), 32'd1);
    chk("rst_pre_data", 32'(od0), 32'hAA);
    chk("rst_pre_sel", 32'(os0), 32'd2);
    chk("rr_pre_sel", 32'(os1), 32'd1);
    iv[0] = 4'b0000;
    iv[1] = 4'b0000;
    @(posedge clk); #1;
    chk("stall_full_ready", 32'(ir0), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(ov0), 32'd0);
    chk("rst_async_data", 32'(od0), 32'd0);
    chk("rst_async_sel", 32'(os0), 32'd0);
    chk("rst_async_data_u1", 32'(od1), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Fixed priority with channels 1 and 3 requesting.
    @(posedge clk); #1;
    iv[0] = 4'b1010; idat[0][1] = 8'h21; idat[0][3] = 8'h23; ordy[0] = 1'b1;
    #1;
    chk("fp_ready_first", 32'(ir0), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("fp_sel", 32'(os0), 32'd1);
      chk("fp_data", 32'(od0), 32'h21);
      chk("fp_ch3_ready", 32'(ir0[3]), 32'd0);
    end
    iv[0] = 4'b0000;

    // Round-robin over three channels; pointer must restart at 0 after reset.
    iv[1] = 4'b0111; ordy[1] = 1'b1;
    idat[1][0] = 8'h10; idat[1][1] = 8'h11; idat[1][2] = 8'h12;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rr_data", 32'(od1), 32'(rr_exp[i]));
      chk("rr_valid", 32'(ov1), 32'd1);
    end
    iv[1] = 4'b0000;

    // Backpressure, simultaneous drain+refill, then idle drain on u2.
    ordy[2] = 1'b1; iv[2] = 4'b0001; idat[2][0] = 8'h05; idat[2][1] = 8'h06;
    @(posedge clk); #1;
    chk("bp_first_data", 32'(od2), 32'h05);
    ordy[2] = 1'b0; iv[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 32'(od2), 32'h05);
      chk("bp_hold_sel", 32'(os2), 32'd0);
      chk("bp_hold_ready", 32'(ir2), 32'd0);
      chk("bp_hold_valid", 32'(ov2), 32'd1);
    end
    ordy[2] = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ir2), 32'b10);
    @(posedge clk); #1;
    chk("bp_refill_data", 32'(od2), 32'h06);
    chk("bp_refill_sel", 32'(os2), 32'd1);
    chk("bp_refill_valid", 32'(ov2), 32'd1);
    iv[2] = 4'b0000;
    @(posedge clk); #1;
    chk("idle_drain_valid", 32'(ov2), 32'd0);
    chk("idle_drain_data", 32'(od2), 32'h06);
    iv[2] = 4'b0011;
    #1;
    chk("idle_ptr_kept", 32'(ir2), 32'b01);
    @(posedge clk); #1;
    iv[2] = 4'b0000;

    // Single channel back-to-back.
    iv[3] = 4'b0001; ordy[3] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idat[3][0] = 8'(i);
      @(posedge clk); #1;
      chk("b2b_data", 32'(od3), 32'(i));
      chk("b2b_valid", 32'(ov3), 32'd1);
      chk("b2b_sel", 32'(os3), 32'd0);
    end
    iv[3] = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Registered, parametrised N-way arbitrating multiplexer with valid/ready handshakes on every input and on the output. It replaces combinational first-match selection wherever several requesters share one downstream consumer, e.g. I-fetch, D-cache and page-walker requests into the single memory-request port. Arbitration is selectable between fixed priority (lowest index wins) and round-robin. The winner is captured in a one-entry output register, giving one cycle of latency and full throughput under continuous `out_ready`.

## Interface
- `WIDTH`, 64: payload width in bits.
- `CNT`, 2: number of input channels, ≥1.
- `RR`, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- `SELW`, derived: `(CNT>1) ? $clog2(CNT) : 1`, the width of `out_sel`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  CNT  per-channel request valid.
- `in_data`  in  WIDTH × CNT (unpacked `[CNT-1:0]`)  per-channel payload.
- `in_ready`  out  CNT  per-channel accept, combinational, one-hot or zero.
- `out_valid`  out  1  output register holds a payload.
- `out_data`  out  WIDTH  registered payload.
- `out_sel`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  downstream accept.

## Operation
- Storage: one output entry (`out_valid`, `out_data`, `out_sel`) and the round-robin pointer `ptr` (SELW bits). The pointer is only used when `RR=1`.
- Output states:
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
- Capacity term: `space = !out_valid || out_ready`.
- Grant (combinational from `in_valid`):
  - `RR=0`: the lowest index i with `in_valid[i]=1`.
  - `RR=1`: the first valid index scanning i = ptr, ptr+1, …, CNT-1, 0, …, ptr-1 (wrap mod CNT).
  - No valid input: no grant.
- Ready and accept:
  - `in_ready[i] = grant[i] && space`.
  - At most one bit of `in_ready` is ever high.
  - Input handshake (accept) = `in_valid[i] && in_ready[i]`.
- Transitions:
  - EMPTY + accept → FULL: capture `in_data[g]` and `g`.
  - EMPTY, no accept → EMPTY.
  - FULL + `out_ready` + accept → FULL: new payload replaces the old one in the same edge (back-to-back).
  - FULL + `out_ready`, no accept → EMPTY.
  - FULL + `!out_ready` → FULL, with `out_data`/`out_sel` held stable and every `in_ready` at 0.
- Pointer (`RR=1`): on accept of channel g, `ptr <= (g==CNT-1) ? 0 : g+1`. Without an accept, `ptr` is unchanged. Non-power-of-two CNT must wrap at CNT-1, not at 2^SELW-1.
- `CNT=1`: the grant is `in_valid[0]`, `out_sel` is constantly 0 and `ptr` is constantly 0.
- Requesters hold `in_valid`/`in_data` until their handshake. The block does not require this, and it does not need to enforce the rule.
- `out_data` is updated only on accept; it is not cleared on drain.
- No combinational path from `in_valid`/`in_data` to `out_*`. The only combinational path to `in_ready` is from `in_valid` and `out_ready`.

## Timing
- Reset (async assert, any time including mid-transfer): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0` immediately.
  - `in_ready` is then driven only by the grant logic, since `space=1`.
  - An in-flight payload is dropped.
- Latency: input accepted on edge N → `out_valid=1` with that payload from edge N until the drain edge.
- Throughput: one transfer per cycle while `out_ready=1` and any `in_valid=1`.
- Stall: while `!out_ready && out_valid`, `in_ready=0`, and `out_data`/`out_sel` do not change.
- Simultaneous drain and refill in one edge is legal and loses no cycle.
- Simultaneous requests: exactly one accepted per cycle; the others see `in_ready=0` and keep waiting.

## Test plan
- Reset mid-operation: CNT=4, FULL with `out_data=0xAA` and `out_ready=0`; assert `rst` between edges → `out_valid`, `out_data`, `out_sel` go to 0 before the next edge; `ptr=0` after release.
- Fixed priority: RR=0, CNT=4, `in_valid=4'b1010` held, `out_ready=1` → `out_sel` shows 1, 1, 1…; channel 3 never gets `in_ready`.
- Round-robin fairness: RR=1, CNT=3 (non-power-of-two), all valid, `out_ready=1`, data = 0x10/0x11/0x12 → outputs 0x10, 0x11, 0x12, 0x10…; `ptr` sequence 1, 2, 0, 1.
- Backpressure: RR=1, CNT=2, accept 0x5 from ch0, then `out_ready=0` for 3 cycles with ch1 valid → `out_data=0x5`/`out_sel=0` held and `in_ready=2'b00`; raise `out_ready` → in that same edge 0x5 drains and ch1 is accepted.
- Back-to-back: CNT=1, `in_valid=1`, `out_ready=1`, data 1, 2, 3 on consecutive cycles → `out_data` 1, 2, 3 on consecutive cycles with `out_valid` continuously 1.
- Idle drain: FULL, `out_ready=1`, no `in_valid` → EMPTY next cycle with `out_data` retained; `ptr` unchanged.
